// File: rtl/timer_6502.sv
// timer_6502: memory-mapped 16-bit programmable interval timer for the 6502 SoC.
// A prescaler divides clk by PRESCALE into timer ticks. Each tick decrements
// COUNT. A tick that finds COUNT at zero is a timeout: it reloads COUNT and
// sets TF. The level IRQ is IE & TF, and read data is registered.
//
// Register map (rs):
//   0 CTRL   R/W  bit0 EN, bit1 IE, bit2 ONESHOT
//   1 STATUS R    bit0 TF, bit1 EN ; W din[0]=1 clears TF
//   2 COUNT  W    stage RELOAD_LO ; R live COUNT[7:0], latches COUNT[15:8]
//   3 COUNT  W    RELOAD_HI + load COUNT ; R latched high byte (SNAP_HI)
module timer_6502 #(
  parameter int PRESCALE = 16,
  parameter int PSC_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  localparam logic [1:0]       RS_CTRL   = 2'd0;
  localparam logic [1:0]       RS_STATUS = 2'd1;
  localparam logic [1:0]       RS_LO     = 2'd2;
  localparam logic [1:0]       RS_HI     = 2'd3;
  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(PRESCALE - 1);

  logic             ctrl_en;
  logic             ctrl_ie;
  logic             ctrl_oneshot;
  logic             tf;
  logic [7:0]       reload_lo;
  logic [7:0]       reload_hi;
  logic [7:0]       snap_hi;
  logic [15:0]      count;
  logic [PSC_W-1:0] psc;

  logic             bus_wr;
  logic             bus_rd;
  logic             wr_ctrl;
  logic             wr_status;
  logic             wr_lo;
  logic             wr_hi;
  logic             tick;
  logic             timeout;
  logic [15:0]      reload;
  logic [7:0]       rd_data;

  // Bus decode and tick/timeout qualification
  always_comb begin
    bus_wr    = cs & we;
    bus_rd    = cs & ~we;
    wr_ctrl   = bus_wr & (rs == RS_CTRL);
    wr_status = bus_wr & (rs == RS_STATUS);
    wr_lo     = bus_wr & (rs == RS_LO);
    wr_hi     = bus_wr & (rs == RS_HI);
    reload    = {reload_hi, reload_lo};
    tick      = ctrl_en & (psc == PSC_LAST);
    // A counter load on the same edge as a tick swallows the tick entirely.
    timeout   = tick & ~wr_hi & (count == 16'd0);
  end

  // Control register; a CTRL write overrides a one-shot auto-disable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en      <= 1'b0;
      ctrl_ie      <= 1'b0;
      ctrl_oneshot <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en      <= din[0];
      ctrl_ie      <= din[1];
      ctrl_oneshot <= din[2];
    end else if (timeout && ctrl_oneshot) begin
      ctrl_en      <= 1'b0;
    end
  end

  // Timeout flag; a timeout beats a simultaneous software clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tf <= 1'b0;
    end else if (timeout) begin
      tf <= 1'b1;
    end else if (wr_status && din[0]) begin
      tf <= 1'b0;
    end
  end

  // Reload value, written low byte first then high byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
    end else begin
      if (wr_lo) reload_lo <= din;
      if (wr_hi) reload_hi <= din;
    end
  end

  // Prescaler: held at zero while disabled, restarted by a counter load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
    end else if (!ctrl_en || wr_hi) begin
      psc <= '0;
    end else if (psc == PSC_LAST) begin
      psc <= '0;
    end else begin
      psc <= psc + PSC_W'(1);
    end
  end

  // Main down-counter: load from bus, otherwise decrement/reload on tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'h0000;
    end else if (wr_hi) begin
      count <= {din, reload_lo};
    end else if (tick) begin
      if (count == 16'd0) count <= reload;
      else                count <= count - 16'd1;
    end
  end

  // Read mux for the registered data path
  always_comb begin
    rd_data = 8'h00;
    case (rs)
      RS_CTRL:   rd_data = {5'b0, ctrl_oneshot, ctrl_ie, ctrl_en};
      RS_STATUS: rd_data = {6'b0, ctrl_en, tf};
      RS_LO:     rd_data = count[7:0];
      RS_HI:     rd_data = snap_hi;
      default:   rd_data = 8'h00;
    endcase
  end

  // Registered read data; reading the low byte freezes the high byte
  // so a two-access 16-bit read is coherent while the counter runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout    <= 8'h00;
      snap_hi <= 8'h00;
    end else if (bus_rd) begin
      dout <= rd_data;
      if (rs == RS_LO) snap_hi <= count[15:8];
    end
  end

  assign irq = ctrl_ie & tf;

endmodule

// File: tb/tb_timer_6502.sv
// Self-checking bench for timer_6502: directed scenarios with fixed expected
// values plus a randomized bus phase, all compared against an abstract model.
module tb_timer_6502;

  localparam int PRESCALE = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       cs    = 1'b0;
  logic       we    = 1'b0;
  logic [1:0] rs    = 2'd0;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state (plain integers)
  int m_en, m_ie, m_os, m_tf;
  int m_lo, m_hi, m_count, m_clks, m_snap, m_dout;

  timer_6502 #(.PRESCALE(PRESCALE), .PSC_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .cs   (cs),
    .we   (we),
    .rs   (rs),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_os = 0; m_tf = 0;
    m_lo = 0; m_hi = 0; m_count = 0; m_clks = 0; m_snap = 0; m_dout = 0;
  endtask

  // One clock edge of the timer, from the register-map rules. m_clks counts
  // enabled clocks since the last (re)start; every PRESCALE-th one is a tick.
  task automatic model_edge(input logic c, input logic w, input logic [1:0] r, input logic [7:0] d);
    bit wr      = c && w;
    bit rd      = c && !w;
    bit load    = wr && (r == 2'd3);
    int reload  = m_hi * 256 + m_lo;
    int clks    = m_clks;
    bit tick    = 0;
    bit timeout;
    if (m_en != 0) begin
      clks = m_clks + 1;
      tick = (clks % PRESCALE) == 0;
    end
    timeout = tick && !load && (m_count == 0);
    if (rd) begin
      case (r)
        2'd0: m_dout = m_os * 4 + m_ie * 2 + m_en;
        2'd1: m_dout = m_en * 2 + m_tf;
        2'd2: begin m_dout = m_count % 256; m_snap = m_count / 256; end
        default: m_dout = m_snap;
      endcase
    end
    if (load) begin
      m_count = int'(d) * 256 + m_lo;
      clks = 0;
    end else if (tick) begin
      m_count = (m_count == 0) ? reload : m_count - 1;
    end
    if (timeout) m_tf = 1;
    else if (wr && r == 2'd1 && d[0]) m_tf = 0;
    if (wr && r == 2'd0) begin
      if (m_en == 0 && d[0]) clks = 0;
      m_en = int'(d[0]); m_ie = int'(d[1]); m_os = int'(d[2]);
    end else if (timeout && m_os != 0) begin
      m_en = 0;
    end
    if (wr && r == 2'd2) m_lo = int'(d);
    if (wr && r == 2'd3) m_hi = int'(d);
    m_clks = clks;
  endtask

  task automatic do_cycle(input logic c, input logic w, input logic [1:0] r, input logic [7:0] d);
    cs = c; we = w; rs = r; din = d;
    @(posedge clk);
    model_edge(c, w, r, d);
    #1;
    cyc++;
    check("model_dout", 16'(dout), 16'(m_dout));
    check("model_irq", 16'(irq), 16'(m_ie & m_tf));
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wr_reg(input logic [1:0] r, input logic [7:0] d);
    do_cycle(1'b1, 1'b1, r, d);
  endtask

  task automatic rd_reg(input logic [1:0] r);
    do_cycle(1'b1, 1'b0, r, 8'h00);
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) idle();
  endtask

  initial begin
    int c0;
    int sel;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset values of all registers
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r));
      check("reset_read", 16'(dout), 16'h00);
    end
    check("reset_irq", 16'(irq), 16'h0);

    // Periodic: RELOAD=3 -> timeout every 64 clocks
    wr_reg(2'd2, 8'h03);
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd0, 8'h03);
    c0 = cyc;
    idle_until(c0 + 63);
    check("periodic_pre_irq", 16'(irq), 16'h0);
    idle();
    check("periodic_irq", 16'(irq), 16'h1);
    rd_reg(2'd1);
    check("periodic_status", 16'(dout), 16'h03);
    wr_reg(2'd1, 8'h01);
    check("periodic_clear", 16'(irq), 16'h0);
    idle_until(c0 + 127);
    check("periodic2_pre_irq", 16'(irq), 16'h0);
    idle();
    check("periodic2_irq", 16'(irq), 16'h1);

    // Collision: clear on the exact timeout edge loses to the set
    wr_reg(2'd1, 8'h01);
    check("coll_preclear", 16'(irq), 16'h0);
    idle_until(c0 + 191);
    wr_reg(2'd1, 8'h01);
    check("coll_set_wins", 16'(irq), 16'h1);
    wr_reg(2'd1, 8'h01);
    check("coll_second_clear", 16'(irq), 16'h0);
    rd_reg(2'd1);
    check("coll_status", 16'(dout), 16'h02);

    // Snapshot of a stopped counter
    wr_reg(2'd0, 8'h00);
    wr_reg(2'd2, 8'h34);
    wr_reg(2'd3, 8'h12);
    check("dout_hold", 16'(dout), 16'h02);
    rd_reg(2'd2);
    check("snap_lo", 16'(dout), 16'h34);
    rd_reg(2'd3);
    check("snap_hi", 16'(dout), 16'h12);

    // One-shot: RELOAD=1 -> single timeout after 32 clocks, then stopped
    wr_reg(2'd2, 8'h01);
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd0, 8'h07);
    c0 = cyc;
    idle_until(c0 + 31);
    check("oneshot_pre_irq", 16'(irq), 16'h0);
    idle();
    check("oneshot_irq", 16'(irq), 16'h1);
    rd_reg(2'd1);
    check("oneshot_status", 16'(dout), 16'h01);
    repeat (200) idle();
    rd_reg(2'd2);
    check("oneshot_count_lo", 16'(dout), 16'h01);
    rd_reg(2'd3);
    check("oneshot_count_hi", 16'(dout), 16'h00);
    check("oneshot_irq_held", 16'(irq), 16'h1);

    // Asynchronous reset mid-count with COUNT=0x80 and irq high
    wr_reg(2'd0, 8'h00);
    wr_reg(2'd1, 8'h01);
    wr_reg(2'd2, 8'h80);
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd0, 8'h03);
    c0 = cyc;
    idle_until(c0 + 2063);
    check("long_pre_irq", 16'(irq), 16'h0);
    idle();
    check("long_irq", 16'(irq), 16'h1);
    rd_reg(2'd2);
    check("long_count", 16'(dout), 16'h80);
    idle();
    reset = 1'b0;
    #2;
    model_reset();
    check("async_rst_irq", 16'(irq), 16'h0);
    check("async_rst_dout", 16'(dout), 16'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    rd_reg(2'd0);
    check("post_rst_ctrl", 16'(dout), 16'h00);
    rd_reg(2'd2);
    check("post_rst_count", 16'(dout), 16'h00);
    wr_reg(2'd2, 8'h05);
    wr_reg(2'd3, 8'h00);
    repeat (100) idle();
    rd_reg(2'd2);
    check("post_rst_no_ticks", 16'(dout), 16'h05);
    check("post_rst_irq", 16'(irq), 16'h0);

    // Randomized bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 35) begin
        idle();
      end else if (sel < 45) begin
        do_cycle(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
      end else if (sel < 72) begin
        rd_reg(2'($urandom));
      end else if (sel < 84) begin
        wr_reg(2'd0, 8'($urandom) | 8'(($urandom_range(0, 3) != 0) ? 1 : 0));
      end else if (sel < 93) begin
        wr_reg(2'd1, 8'($urandom));
      end else begin
        wr_reg(2'd2, 8'($urandom_range(0, 3)));
        wr_reg(2'd3, 8'(($urandom_range(0, 19) == 0) ? 1 : 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
